// File: rtl/radix4_fft_pkg.sv
// Shared types, constants and arithmetic helpers for the radix-4 DIF FFT engine.
package radix4_fft_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int TW_W_DEF   = 16;
  localparam int STAGES_DEF = 2;
  localparam int N          = 4 ** STAGES_DEF;
  // Container width for complex operands; wide enough for any legal DATA_W/TW_W
  localparam int MAX_W      = 32;
  // Twiddle generator constants
  localparam real TW_PI     = 3.14159265358979323846;

  typedef enum logic [1:0] {
    ST_LOAD    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_UNLOAD  = 2'd2
  } state_t;

  typedef struct packed {
    logic signed [MAX_W-1:0] re;
    logic signed [MAX_W-1:0] im;
  } cplx_t;

  typedef struct packed {
    logic                ovf;
    logic signed [63:0]  val;
  } sat_t;

  typedef struct packed {
    logic  ovf;
    cplx_t y3;
    cplx_t y2;
    cplx_t y1;
    cplx_t y0;
  } bfly_t;

  // Quantise a real twiddle component to Q2.(tw_w-2), rounding to nearest
  function automatic int tw_quant(input real v, input int tw_w);
    real s;
    s = v * (2.0 ** (tw_w - 2));
    return $rtoi($floor(s + 0.5));
  endfunction

  // Reverse the base-4 digits of idx (stages digits)
  function automatic int digitrev4(input int idx, input int stages);
    int r;
    int v;
    r = 0;
    v = idx;
    for (int s = 0; s < stages; s++) begin
      r = (r << 2) | (v & 3);
      v = v >> 2;
    end
    return r;
  endfunction

  // Arithmetic right shift with round-half-up
  function automatic logic signed [63:0] rshift_round(input logic signed [63:0] v, input int sh);
    if (sh <= 0) return v;
    return (v + (64'sd1 <<< (sh - 1))) >>> sh;
  endfunction

  // Round-shift then saturate to a w-bit two's complement range
  function automatic sat_t sat_round(input logic signed [63:0] value, input int shift, input int w);
    sat_t               r;
    logic signed [63:0] v;
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    v     = rshift_round(value, shift);
    max_v = (64'sd1 <<< (w - 1)) - 64'sd1;
    min_v = -(64'sd1 <<< (w - 1));
    r.ovf = 1'b0;
    r.val = v;
    if (v > max_v) begin
      r.ovf = 1'b1;
      r.val = max_v;
    end else if (v < min_v) begin
      r.ovf = 1'b1;
      r.val = min_v;
    end
    return r;
  endfunction

  // One radix-4 DIF butterfly: four sums, twiddle products on y1..y3, optional /4, saturation
  function automatic bfly_t butterfly(input cplx_t a, input cplx_t b, input cplx_t c, input cplx_t d,
                                      input cplx_t w1, input cplx_t w2, input cplx_t w3,
                                      input int data_w, input int tw_w, input logic scale);
    bfly_t              r;
    logic signed [63:0] ar, ai, br, bi, cr, ci, dr, di;
    logic signed [63:0] s_re [4];
    logic signed [63:0] s_im [4];
    logic signed [63:0] w_re [4];
    logic signed [63:0] w_im [4];
    logic signed [63:0] p_re, p_im;
    sat_t               q_re, q_im;
    cplx_t              y [4];
    int                 sh;
    ar = 64'($signed(a.re)); ai = 64'($signed(a.im));
    br = 64'($signed(b.re)); bi = 64'($signed(b.im));
    cr = 64'($signed(c.re)); ci = 64'($signed(c.im));
    dr = 64'($signed(d.re)); di = 64'($signed(d.im));
    w_re[0] = 64'sd0;              w_im[0] = 64'sd0;
    w_re[1] = 64'($signed(w1.re)); w_im[1] = 64'($signed(w1.im));
    w_re[2] = 64'($signed(w2.re)); w_im[2] = 64'($signed(w2.im));
    w_re[3] = 64'($signed(w3.re)); w_im[3] = 64'($signed(w3.im));
    s_re[0] = ar + br + cr + dr;   s_im[0] = ai + bi + ci + di;
    s_re[1] = ar + bi - cr - di;   s_im[1] = ai - br - ci + dr;
    s_re[2] = ar - br + cr - dr;   s_im[2] = ai - bi + ci - di;
    s_re[3] = ar - bi - cr + di;   s_im[3] = ai + br - ci - dr;
    sh = scale ? 2 : 0;
    r.ovf = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 0) begin
        p_re = s_re[0];
        p_im = s_im[0];
      end else begin
        p_re = rshift_round(s_re[i] * w_re[i] - s_im[i] * w_im[i], tw_w - 2);
        p_im = rshift_round(s_re[i] * w_im[i] + s_im[i] * w_re[i], tw_w - 2);
      end
      q_re = sat_round(p_re, sh, data_w);
      q_im = sat_round(p_im, sh, data_w);
      y[i].re = MAX_W'(q_re.val);
      y[i].im = MAX_W'(q_im.val);
      r.ovf = r.ovf | q_re.ovf | q_im.ovf;
    end
    r.y0 = y[0];
    r.y1 = y[1];
    r.y2 = y[2];
    r.y3 = y[3];
    return r;
  endfunction

endpackage

// File: rtl/radix4_fft_seq_twiddle_rom.sv
// Combinational twiddle ROM: idx -> W^idx = (cos, -sin)(2*pi*idx/NP) in Q2.(TW_W-2), 3*NP/4 entries.
module radix4_twiddle_rom
  import radix4_fft_pkg::*;
#(
  parameter int TW_W = 16,
  parameter int NP   = 16,
  parameter int IW   = 4
) (
  input  logic [IW-1:0]          idx,
  output logic signed [TW_W-1:0] w_re,
  output logic signed [TW_W-1:0] w_im
);
  localparam int ENTRIES = 3 * NP / 4;

  logic signed [TW_W-1:0] tab_re [ENTRIES];
  logic signed [TW_W-1:0] tab_im [ENTRIES];

  for (genvar i = 0; i < ENTRIES; i++) begin : g_tab
    localparam real ANG = 2.0 * TW_PI * real'(i) / real'(NP);
    localparam int  C_Q = tw_quant($cos(ANG), TW_W);
    localparam int  S_Q = tw_quant(-$sin(ANG), TW_W);
    assign tab_re[i] = TW_W'(C_Q);
    assign tab_im[i] = TW_W'(S_Q);
  end

  // Table lookup; indices beyond the table return zero
  always_comb begin
    w_re = '0;
    w_im = '0;
    if (int'(idx) < ENTRIES) begin
      w_re = tab_re[idx];
      w_im = tab_im[idx];
    end
  end

endmodule

// File: rtl/radix4_fft_seq.sv
// Iterative radix-4 DIF FFT: load frame, in-place butterflies through one shared datapath,
// natural-order unload via digit reversal. Define FFT_STAGE_SCALE_EN for a /4 per stage.
// Handshakes: a transfer happens on a rising clk edge where valid & ready are both high;
// the producer holds data stable while valid & !ready.
module radix4_fft_seq
  import radix4_fft_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int TW_W   = TW_W_DEF,
  parameter int STAGES = STAGES_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic signed [DATA_W-1:0] s_re,
  input  logic signed [DATA_W-1:0] s_im,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic signed [DATA_W-1:0] m_re,
  output logic signed [DATA_W-1:0] m_im,
  output logic                     m_last,
  output logic                     busy,
  output logic                     ovf,
  output state_t                   dbg_state
);
  localparam int NP    = 4 ** STAGES;
  localparam int AW    = 2 * STAGES;
  localparam int NB    = NP / 4;
  localparam int TW_N  = 3 * NP / 4;
  localparam int TW_IW = (TW_N > 1) ? $clog2(TW_N) : 1;
`ifdef FFT_STAGE_SCALE_EN
  localparam logic SCALE = 1'b1;
`else
  localparam logic SCALE = 1'b0;
`endif

  state_t state, state_nxt;
  logic signed [DATA_W-1:0] mem_re [NP];
  logic signed [DATA_W-1:0] mem_im [NP];
  logic [AW-1:0]  load_cnt;
  logic [1:0]     stage;
  logic [AW-1:0]  bidx;
  logic [AW:0]    out_cnt;
  logic           primed;
  logic [AW-1:0]  addr [4];
  logic [AW-1:0]  rd_addr;
  logic [TW_IW-1:0] tw_idx [3];
  logic signed [TW_W-1:0] tw_re [3];
  logic signed [TW_W-1:0] tw_im [3];
  cplx_t          opnd [4];
  cplx_t          wt [3];
  bfly_t          bf;
  int             span_i, k_i, g_i, base_i, kp_i;
  logic           s_fire, last_bfly, unload_adv, frame_done;

  assign s_fire     = s_valid & s_ready;
  assign last_bfly  = (stage == 2'(STAGES - 1)) && (bidx == AW'(NB - 1));
  assign unload_adv = primed && (!m_valid || m_ready);
  assign frame_done = unload_adv && m_valid && m_last;
  assign busy       = (state != ST_LOAD);
  assign dbg_state  = state;
  assign rd_addr    = AW'(digitrev4(int'(out_cnt[AW-1:0]), STAGES));

  // Butterfly operand addresses and twiddle exponents for the current stage/index
  always_comb begin
    span_i = NP >> (2 * (int'(stage) + 1));
    if (span_i == 0) span_i = 1;
    k_i    = int'(bidx) % span_i;
    g_i    = int'(bidx) / span_i;
    base_i = g_i * 4 * span_i + k_i;
    kp_i   = k_i << (2 * int'(stage));
    for (int i = 0; i < 4; i++) addr[i] = AW'(base_i + i * span_i);
    for (int i = 0; i < 3; i++) tw_idx[i] = TW_IW'((i + 1) * kp_i);
  end

  for (genvar t = 0; t < 3; t++) begin : g_rom
    radix4_twiddle_rom #(.TW_W(TW_W), .NP(NP), .IW(TW_IW)) u_rom (
      .idx  (tw_idx[t]),
      .w_re (tw_re[t]),
      .w_im (tw_im[t])
    );
  end

  // Pack operands and twiddles into the container type and evaluate the butterfly
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      opnd[i].re = MAX_W'(mem_re[addr[i]]);
      opnd[i].im = MAX_W'(mem_im[addr[i]]);
    end
    for (int i = 0; i < 3; i++) begin
      wt[i].re = MAX_W'(tw_re[i]);
      wt[i].im = MAX_W'(tw_im[i]);
    end
    bf = butterfly(opnd[0], opnd[1], opnd[2], opnd[3], wt[0], wt[1], wt[2], DATA_W, TW_W, SCALE);
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_LOAD;
    else     state <= state_nxt;
  end

  // FSM next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_LOAD:    if (s_fire && load_cnt == AW'(NP - 1)) state_nxt = ST_COMPUTE;
      ST_COMPUTE: if (last_bfly) state_nxt = ST_UNLOAD;
      ST_UNLOAD:  if (frame_done) state_nxt = ST_LOAD;
      default:    state_nxt = ST_LOAD;
    endcase
  end

  // Counters, flags and the registered output stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_ready  <= 1'b0;
      m_valid  <= 1'b0;
      m_last   <= 1'b0;
      m_re     <= '0;
      m_im     <= '0;
      ovf      <= 1'b0;
      load_cnt <= '0;
      stage    <= '0;
      bidx     <= '0;
      out_cnt  <= '0;
      primed   <= 1'b0;
    end else begin
      s_ready <= (state_nxt == ST_LOAD);
      case (state)
        ST_LOAD: begin
          if (s_fire) begin
            load_cnt <= load_cnt + 1'b1;
            if (load_cnt == '0) ovf <= 1'b0;
          end
        end
        ST_COMPUTE: begin
          if (bf.ovf) ovf <= 1'b1;
          if (last_bfly) begin
            stage   <= '0;
            bidx    <= '0;
            primed  <= 1'b0;
            out_cnt <= '0;
          end else if (bidx == AW'(NB - 1)) begin
            bidx  <= '0;
            stage <= stage + 2'd1;
          end else begin
            bidx <= bidx + 1'b1;
          end
        end
        ST_UNLOAD: begin
          // First UNLOAD cycle only arms the output stage
          primed <= 1'b1;
          if (unload_adv) begin
            if (m_valid && m_last) begin
              m_valid <= 1'b0;
              m_last  <= 1'b0;
            end else begin
              m_valid <= 1'b1;
              m_re    <= mem_re[rd_addr];
              m_im    <= mem_im[rd_addr];
              m_last  <= (out_cnt == (AW + 1)'(NP - 1));
              out_cnt <= out_cnt + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Sample buffer: natural-order load, in-place butterfly write-back
  always_ff @(posedge clk) begin
    if (state == ST_LOAD && s_fire) begin
      mem_re[load_cnt] <= s_re;
      mem_im[load_cnt] <= s_im;
    end else if (state == ST_COMPUTE) begin
      mem_re[addr[0]] <= bf.y0.re[DATA_W-1:0];
      mem_im[addr[0]] <= bf.y0.im[DATA_W-1:0];
      mem_re[addr[1]] <= bf.y1.re[DATA_W-1:0];
      mem_im[addr[1]] <= bf.y1.im[DATA_W-1:0];
      mem_re[addr[2]] <= bf.y2.re[DATA_W-1:0];
      mem_im[addr[2]] <= bf.y2.im[DATA_W-1:0];
      mem_re[addr[3]] <= bf.y3.re[DATA_W-1:0];
      mem_im[addr[3]] <= bf.y3.im[DATA_W-1:0];
    end
  end

endmodule

// File: tb/tb_radix4_fft_seq.sv
// Directed bench for radix4_fft_seq (STAGES=2, N=16, DATA_W=16).
module tb_radix4_fft_seq;
  import radix4_fft_pkg::*;

  localparam int DW = 16;
  localparam int NP = 16;
`ifdef FFT_STAGE_SCALE_EN
  localparam int IMP_EXP = 63;
  localparam int DC_EXP  = 100;
  localparam int TONE_PK = 1000;
  localparam int TONE_TL = 4;
  localparam int DIV     = 16;
  localparam int SAT_EXP = 30000;
  localparam int SAT_OVF = 0;
`else
  localparam int IMP_EXP = 1000;
  localparam int DC_EXP  = 1600;
  localparam int TONE_PK = 16000;
  localparam int TONE_TL = 16;
  localparam int DIV     = 1;
  localparam int SAT_EXP = 32767;
  localparam int SAT_OVF = 1;
`endif

  // Clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic                 s_valid = 1'b0;
  logic                 s_ready;
  logic signed [DW-1:0] s_re = '0;
  logic signed [DW-1:0] s_im = '0;
  logic                 m_valid;
  logic                 m_ready = 1'b0;
  logic signed [DW-1:0] m_re;
  logic signed [DW-1:0] m_im;
  logic                 m_last;
  logic                 busy;
  logic                 ovf;
  state_t               dbg_state;

  int checks   = 0;
  int failures = 0;
  int in_re [NP];
  int in_im [NP];
  logic signed [31:0] rec_re [NP];
  logic signed [31:0] rec_im [NP];
  logic               rec_last [NP];
  // round(1000*cos(2*pi*n/16))
  int c16 [NP] = '{1000, 924, 707, 383, 0, -383, -707, -924,
                   -1000, -924, -707, -383, 0, 383, 707, 924};

  radix4_fft_seq dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_re(s_re), .s_im(s_im),
    .m_valid(m_valid), .m_ready(m_ready), .m_re(m_re), .m_im(m_im), .m_last(m_last),
    .busy(busy), .ovf(ovf), .dbg_state(dbg_state)
  );

  // Scoreboard comparisons
  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_tol(input string tag, input logic signed [63:0] obs, input int exp, input int tol);
    checks++;
    assert (obs >= exp - tol && obs <= exp + tol) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d+-%0d", tag, obs, exp, tol);
    end
  endtask

  // Driver: push in_re/in_im as one frame; called and returns on a falling edge
  task automatic send_frame(input bit chk_ovf);
    int guard;
    for (int n = 0; n < NP; n++) begin
      s_valid = 1'b1;
      s_re    = DW'(in_re[n]);
      s_im    = DW'(in_im[n]);
      guard   = 0;
      while (s_ready !== 1'b1 && guard < 200) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 200) begin
        chk("s_ready_timeout", s_ready, 1);
        break;
      end
      @(negedge clk);
      if (chk_ovf && n == 0) chk("ovf_clear_on_first_sample", ovf, 0);
    end
    s_valid = 1'b0;
  endtask

  // Driver/monitor for the output side; mode 1 applies backpressure
  task automatic recv_frame(input int mode);
    int got = 0;
    int cyc = 0;
    int stall = 0;
    bit held = 0;
    logic signed [DW-1:0] hre = '0;
    logic signed [DW-1:0] him = '0;
    logic hl = 1'b0;
    while (got < NP && cyc < 400) begin
      if (m_valid === 1'b1) begin
        if (held) begin
          chk("hold_re", m_re, hre);
          chk("hold_im", m_im, him);
          chk("hold_last", m_last, hl);
        end
        if (mode == 1 && got == 7 && stall < 5) begin
          m_ready = 1'b0;
          stall++;
        end else if (mode == 1) m_ready = (cyc % 2 == 0);
        else m_ready = 1'b1;
        if (m_ready) begin
          rec_re[got]   = m_re;
          rec_im[got]   = m_im;
          rec_last[got] = m_last;
          got++;
          held = 0;
        end else begin
          held = 1;
          hre  = m_re;
          him  = m_im;
          hl   = m_last;
        end
      end else begin
        m_ready = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      cyc++;
    end
    m_ready = 1'b0;
    chk("bins_received", got, NP);
  endtask

  // Common end-of-frame checks
  task automatic check_after(input int exp_ovf);
    chk("m_valid_after_frame", m_valid, 0);
    chk("s_ready_after_frame", s_ready, 1);
    chk("ovf", ovf, exp_ovf);
    for (int i = 0; i < NP; i++) chk($sformatf("m_last_bin%0d", i), rec_last[i], (i == NP - 1));
  endtask

  task automatic set_impulse(input int pos, input int amp);
    for (int n = 0; n < NP; n++) begin
      in_re[n] = (n == pos) ? amp : 0;
      in_im[n] = 0;
    end
  endtask

  task automatic check_impulse_bins(input string tag);
    for (int i = 0; i < NP; i++) begin
      chk($sformatf("%s_re%0d", tag, i), rec_re[i], IMP_EXP);
      chk($sformatf("%s_im%0d", tag, i), rec_im[i], 0);
    end
  endtask

  initial begin
    int lat;
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_m_re", m_re, 0);
    chk("rst_m_im", m_im, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_state", dbg_state, ST_LOAD);
    rst = 1'b0;
    chk("s_ready_before_first_edge", s_ready, 0);
    @(negedge clk);
    chk("s_ready_after_release", s_ready, 1);

    // Impulse at n=0 with latency measurement
    set_impulse(0, 1000);
    send_frame(0);
    chk("busy_in_compute", busy, 1);
    chk("s_ready_in_compute", s_ready, 0);
    chk("state_compute", dbg_state, ST_COMPUTE);
    lat = 0;
    while (m_valid !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, 10);
    recv_frame(0);
    check_impulse_bins("imp");
    check_after(0);

    // DC
    for (int n = 0; n < NP; n++) begin
      in_re[n] = 100;
      in_im[n] = 0;
    end
    send_frame(0);
    recv_frame(0);
    for (int i = 0; i < NP; i++) begin
      chk_tol($sformatf("dc_re%0d", i), rec_re[i], (i == 0) ? DC_EXP : 0, 1);
      chk_tol($sformatf("dc_im%0d", i), rec_im[i], 0, 1);
    end
    check_after(0);

    // Tone at bin 1
    for (int n = 0; n < NP; n++) begin
      in_re[n] = c16[n];
      in_im[n] = c16[(n + 12) % NP];
    end
    send_frame(0);
    recv_frame(0);
    for (int i = 0; i < NP; i++) begin
      chk_tol($sformatf("tone_re%0d", i), rec_re[i], (i == 1) ? TONE_PK : 0, TONE_TL);
      chk_tol($sformatf("tone_im%0d", i), rec_im[i], 0, TONE_TL);
    end
    check_after(0);

    // Impulse at n=1 (X[m] = 1000*W^m) under backpressure; stray s_valid while busy
    set_impulse(1, 1000);
    send_frame(0);
    s_valid = 1'b1;
    s_re    = 16'sd7777;
    s_im    = -16'sd7777;
    repeat (5) @(negedge clk);
    s_valid = 1'b0;
    recv_frame(1);
    for (int i = 0; i < NP; i++) begin
      chk_tol($sformatf("bp_re%0d", i), rec_re[i], c16[i] / DIV, 2);
      chk_tol($sformatf("bp_im%0d", i), rec_im[i], -c16[(i + 12) % NP] / DIV, 2);
    end
    check_after(0);

    // Saturation, then an impulse frame clears ovf on its first sample
    for (int n = 0; n < NP; n++) begin
      in_re[n] = 30000;
      in_im[n] = 0;
    end
    send_frame(0);
    recv_frame(0);
    chk("sat_x0_re", rec_re[0], SAT_EXP);
    chk("sat_x0_im", rec_im[0], 0);
    check_after(SAT_OVF);
    set_impulse(0, 1000);
    send_frame(1);
    recv_frame(0);
    check_impulse_bins("post_sat");
    check_after(0);

    // Reset in the 4th compute cycle
    set_impulse(0, 1000);
    send_frame(0);
    repeat (3) @(negedge clk);
    chk("busy_before_abort", busy, 1);
    rst = 1'b1;
    #1;
    chk("abort_m_valid", m_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_s_ready", s_ready, 0);
    chk("abort_state", dbg_state, ST_LOAD);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_s_ready_release", s_ready, 1);
    chk("abort_m_valid_release", m_valid, 0);
    chk("abort_busy_release", busy, 0);
    send_frame(0);
    recv_frame(0);
    check_impulse_bins("post_abort");
    check_after(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
